// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : LS > IF > PF scheduler for the memory controller request
//               channel, with IF anti-starvation, flush abort and idle gap.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_len,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_done,
  output logic [31:0] pf_rdata,
  output logic        m_valid,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_len,
  input  logic        m_done,
  input  logic [31:0] m_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [1:0]       OWN_NONE = 2'd0;
  localparam logic [1:0]       OWN_LS   = 2'd1;
  localparam logic [1:0]       OWN_IF   = 2'd2;
  localparam logic [1:0]       OWN_PF   = 2'd3;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_valid_q, m_valid_d;
  logic              m_wr_q, m_wr_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [2:0]        m_len_q, m_len_d;

  logic [1:0]        w_gnt;
  logic              w_owner_req;
  logic              w_abort;
  logic              w_complete;

  // IF wins over LS once starved; a flush only blocks speculative IF/PF grants.
  always_comb begin
    w_gnt = OWN_NONE;
    if (if_req && !clear && (cnt_q >= LIMIT)) w_gnt = OWN_IF;
    else if (ls_req)                          w_gnt = OWN_LS;
    else if (if_req && !clear)                w_gnt = OWN_IF;
    else if (pf_req && !clear)                w_gnt = OWN_PF;
  end

  always_comb begin
    w_owner_req = 1'b0;
    case (owner_q)
      OWN_LS:  w_owner_req = ls_req;
      OWN_IF:  w_owner_req = if_req;
      OWN_PF:  w_owner_req = pf_req;
      default: w_owner_req = 1'b0;
    endcase
  end

  // Stores have already committed architecturally, so they run to completion.
  assign w_abort    = (state_q == S_BUSY) && !((owner_q == OWN_LS) && m_wr_q) &&
                      (clear || !w_owner_req);
  assign w_complete = (state_q == S_BUSY) && m_done && !w_abort;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_len_d   = m_len_q;
    case (state_q)
      S_IDLE: begin
        if (w_gnt != OWN_NONE) begin
          state_d   = S_BUSY;
          owner_d   = w_gnt;
          m_valid_d = 1'b1;
          m_wr_d    = (w_gnt == OWN_LS) ? ls_wr : 1'b0;
          m_len_d   = (w_gnt == OWN_LS) ? ls_len : 3'd4;
          m_wdata_d = ls_wdata;
          m_addr_d  = (w_gnt == OWN_LS) ? ls_addr :
                      (w_gnt == OWN_IF) ? if_addr : pf_addr;
        end
        if ((w_gnt == OWN_LS) && if_req) begin
          if (cnt_q < LIMIT) cnt_d = cnt_q + CNT_W'(1);
        end else if ((w_gnt == OWN_IF) || !if_req) begin
          cnt_d = '0;
        end
      end
      S_BUSY: begin
        if (w_abort || w_complete) begin
          state_d   = S_GAP;
          owner_d   = OWN_NONE;
          m_valid_d = 1'b0;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_len_q   <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_len_q   <= m_len_d;
    end
  end

  assign ls_done  = rdy && w_complete && (owner_q == OWN_LS);
  assign if_done  = rdy && w_complete && (owner_q == OWN_IF);
  assign pf_done  = rdy && w_complete && (owner_q == OWN_PF);
  assign ls_rdata = m_rdata;
  assign if_rdata = m_rdata;
  assign pf_rdata = m_rdata;

  assign m_valid  = m_valid_q;
  assign m_wr     = m_wr_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_len    = m_len_q;
  assign owner    = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed stimulus with a transaction-level reference model.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        ls_req, ls_wr, if_req, pf_req, m_done;
  logic [31:0] ls_addr, ls_wdata, if_addr, pf_addr, m_rdata;
  logic [2:0]  ls_len;
  logic        ls_done, if_done, pf_done, m_valid, m_wr;
  logic [31:0] ls_rdata, if_rdata, pf_rdata, m_addr, m_wdata;
  logic [2:0]  m_len;
  logic [1:0]  owner;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_len(ls_len), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_rdata(pf_rdata),
    .m_valid(m_valid), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_len(m_len), .m_done(m_done), .m_rdata(m_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the channel (0 = nobody), whether the idle gap
  // is pending, and how many LS wins IF has sat through.
  bit          md_on = 1'b0;
  int          md_owner, md_cnt;
  bit          md_gap;
  logic        md_wr;
  logic [31:0] md_addr, md_wdata;
  logic [2:0]  md_len;

  function automatic bit req_of(input int who);
    case (who)
      1:       return ls_req;
      2:       return if_req;
      3:       return pf_req;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit eligible(input int who);
    if (who == 1) return ls_req;
    return req_of(who) && !clear;
  endfunction

  function automatic bit aborting();
    return (md_owner != 0) && !((md_owner == 1) && md_wr) && (clear || !req_of(md_owner));
  endfunction

  function automatic int done_owner();
    if (rdy && (md_owner != 0) && m_done && !aborting()) return md_owner;
    return 0;
  endfunction

  always @(posedge clk) begin
    int order [3];
    int win;
    win = 0;
    if (!rst) begin
      md_on    <= 1'b1;
      md_owner <= 0;
      md_gap   <= 1'b0;
      md_cnt   <= 0;
      md_wr    <= 1'b0;
      md_addr  <= '0;
      md_wdata <= '0;
      md_len   <= '0;
    end else if (rdy) begin
      if (md_owner != 0) begin
        if (m_done || aborting()) begin
          md_owner <= 0;
          md_gap   <= 1'b1;
        end
      end else if (md_gap) begin
        md_gap <= 1'b0;
      end else begin
        if (if_req && md_cnt >= LIMIT) begin
          order[0] = 2; order[1] = 1; order[2] = 3;
        end else begin
          order[0] = 1; order[1] = 2; order[2] = 3;
        end
        for (int i = 0; i < 3; i++)
          if (win == 0 && eligible(order[i])) win = order[i];
        if (win != 0) begin
          md_owner <= win;
          md_wr    <= (win == 1) ? ls_wr : 1'b0;
          md_len   <= (win == 1) ? ls_len : 3'd4;
          md_wdata <= ls_wdata;
          md_addr  <= (win == 1) ? ls_addr : (win == 2) ? if_addr : pf_addr;
        end
        if (win == 1 && if_req)       md_cnt <= (md_cnt + 1 > LIMIT) ? LIMIT : md_cnt + 1;
        else if (win == 2 || !if_req) md_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin
    int d;
    if (md_on) begin
      d = done_owner();
      chk("m_valid", m_valid, md_owner != 0);
      chk("owner", owner, md_owner);
      chk("ls_done", ls_done, d == 1);
      chk("if_done", if_done, d == 2);
      chk("pf_done", pf_done, d == 3);
      if (md_owner != 0) begin
        chk("m_addr", m_addr, md_addr);
        chk("m_wr", m_wr, md_wr);
        chk("m_len", m_len, md_len);
        if (md_wr) chk("m_wdata", m_wdata, md_wdata);
      end
      if (d == 1) chk("ls_rdata", ls_rdata, m_rdata);
      if (d == 2) chk("if_rdata", if_rdata, m_rdata);
      if (d == 3) chk("pf_rdata", pf_rdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    ls_req = 0; if_req = 0; pf_req = 0; clear = 0; m_done = 0;
    repeat (3) tick();
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    tick();
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    chk(name, m_valid, 1);
  endtask

  initial begin
    rst = 0; rdy = 1; clear = 0; m_done = 0; m_rdata = 0;
    ls_req = 1; if_req = 1; pf_req = 1; ls_wr = 0;
    ls_addr = 32'h40; ls_wdata = 0; ls_len = 3'd2;
    if_addr = 32'h80; pf_addr = 32'hC0;

    // Reset with every request pending
    repeat (2) tick();
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_dones", {ls_done, if_done, pf_done}, 0);
    rst = 1;
    tick();
    chk("first_owner_ls", owner, 1);
    chk("first_addr", m_addr, 32'h40);
    m_done = 1; m_rdata = 32'h11223344;
    #1;
    chk("first_ls_done", ls_done, 1);
    tick();
    settle();

    // Priority and latency: LS then IF, three cycles apart
    ls_req = 1; ls_wr = 0; ls_addr = 32'h100; ls_len = 3'd4;
    if_req = 1; if_addr = 32'h2000;
    tick();
    chk("prio_valid", m_valid, 1);
    chk("prio_addr", m_addr, 32'h100);
    repeat (4) tick();
    m_done = 1; m_rdata = 32'hDEADBEEF;
    #1;
    chk("prio_ls_done", ls_done, 1);
    chk("prio_ls_rdata", ls_rdata, 32'hDEADBEEF);
    tick();
    m_done = 0; ls_req = 0;
    chk("gap_valid_1", m_valid, 0);
    tick();
    chk("gap_valid_2", m_valid, 0);
    tick();
    chk("if_owner", owner, 2);
    chk("if_len", m_len, 4);
    chk("if_wr", m_wr, 0);
    chk("if_addr", m_addr, 32'h2000);
    m_done = 1;
    tick();
    m_done = 0; if_req = 0;
    settle();

    // Starvation: eight LS wins, then IF takes the ninth grant
    ls_req = 1; ls_wr = 0; ls_addr = 32'h200; ls_len = 3'd4;
    if_req = 1; if_addr = 32'h3000;
    for (int k = 1; k <= 9; k++) begin
      wait_grant("starve_grant");
      chk("starve_owner", owner, (k <= LIMIT) ? 1 : 2);
      m_done = 1; m_rdata = k;
      #1;
      chk("starve_done", (k <= LIMIT) ? ls_done : if_done, 1);
      tick();
      m_done = 0;
      if (k == 9) if_req = 0;
    end
    tick();
    if_req = 1;
    tick();
    chk("cnt_cleared_ls_wins", owner, 1);
    m_done = 1;
    tick();
    settle();

    // Flush during a fetch, then PF held off while clear stays high
    if_req = 1; if_addr = 32'h400; pf_req = 1; pf_addr = 32'h480;
    tick();
    chk("flush_owner", owner, 2);
    tick();
    clear = 1; m_done = 1;
    #1;
    chk("flush_if_done", if_done, 0);
    tick();
    m_done = 0; if_req = 0;
    chk("flush_gap", m_valid, 0);
    tick();
    chk("flush_idle", m_valid, 0);
    tick();
    chk("pf_blocked", m_valid, 0);
    clear = 0;
    tick();
    chk("pf_owner", owner, 3);
    chk("pf_addr", m_addr, 32'h480);
    m_done = 1; m_rdata = 32'hCAFEF00D;
    #1;
    chk("pf_done", pf_done, 1);
    tick();
    settle();

    // Store immunity against flush and request drop
    ls_req = 1; ls_wr = 1; ls_addr = 32'h30000; ls_wdata = 32'h000300FF; ls_len = 3'd1;
    tick();
    chk("st_wdata", m_wdata, 32'h000300FF);
    clear = 1;
    tick();
    clear = 0; ls_req = 0; ls_wdata = 0; ls_addr = 0;
    tick();
    chk("st_valid_held", m_valid, 1);
    chk("st_addr_held", m_addr, 32'h30000);
    chk("st_wdata_held", m_wdata, 32'h000300FF);
    chk("st_len", m_len, 1);
    tick();
    m_done = 1;
    #1;
    chk("st_ls_done", ls_done, 1);
    tick();
    m_done = 0;
    chk("st_released", m_valid, 0);
    settle();

    // rdy freeze with m_done asserted
    ls_wr = 0;
    if_req = 1; if_addr = 32'h500;
    tick();
    rdy = 0; m_done = 1; m_rdata = 32'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("frz_no_done", if_done, 0);
      chk("frz_owner", owner, 2);
      tick();
    end
    rdy = 1;
    #1;
    chk("frz_done", if_done, 1);
    tick();
    m_done = 0; if_req = 0;
    chk("frz_released", m_valid, 0);
    settle();

    // Load aborted by request drop, coincident m_done suppressed
    ls_req = 1; ls_wr = 0; ls_addr = 32'h600; ls_len = 3'd2;
    tick();
    tick();
    ls_req = 0; m_done = 1;
    #1;
    chk("ld_abort_no_done", ls_done, 0);
    tick();
    m_done = 0;
    chk("ld_abort_released", m_valid, 0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
